sequence_controller: RTL
========================

Name: sequence_controller

Overview:
- Sequences the pseudo-random colour generator for the Simon game.
- On each round start, it requests one new colour from the generator and appends it to an internal sequence memory.
- It then plays the whole sequence back as timed LED steps.
- A random-access read port lets the player-input checker compare presses against the stored sequence.

Parameters:
- MAX_LEN, 32: maximum sequence length (entries of 2 bits).
- SHOW_CYCLES, 25: cycles each colour is shown (o_led_valid high). Must be ≥1.
- GAP_CYCLES, 10: dark cycles after each shown colour. Must be ≥1.
- GEN_TIMEOUT, 15: maximum cycles to wait for generator ready after a trigger.
- LEN_W, $clog2(MAX_LEN+1): width of the length/index ports. Derived; do not override.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable. Passed through to o_gen_enable.
- i_start_round  in  1  single-cycle request: append one colour, then play back.
- i_clear  in  1  single-cycle request: empty the sequence.
- o_gen_enable  out  1  generator enable (combinational copy of i_enable).
- o_gen_trigger  out  1  one-cycle generation request to the generator.
- i_gen_ready  in  1  generator value-valid strobe.
- i_gen_value  in  2  generator value. Raw 2-bit code; 2'b00 denotes colour 4.
- o_color  out  2  colour currently shown. Valid while o_led_valid is high.
- o_led_valid  out  1  high during the SHOW phase of each step.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when playback completes.
- o_error  out  1  one-cycle pulse on generator timeout.
- o_full  out  1  high while length == MAX_LEN.
- o_length  out  LEN_W  number of stored colours.
- i_rd_idx  in  LEN_W  read index for the checker.
- o_rd_color  out  2  sequence entry at i_rd_idx. Combinational read; returns 0 if i_rd_idx ≥ o_length.

Behaviour:
- Reset: on i_rst, state=IDLE and length=0. All outputs are 0 except o_gen_enable, which follows i_enable. Memory contents need not be cleared. Reset mid-operation aborts immediately, with no o_done or o_error pulse.
- If i_enable is low, the FSM is forced to IDLE on the next edge. Length and memory are retained.
- States: IDLE, REQ, WAIT_GEN, APPEND, SHOW, GAP, DONE.
- IDLE:
  - i_clear sets length=0 next cycle. It has priority over a simultaneous i_start_round, which is then dropped.
  - i_start_round with i_enable: if o_full, go to SHOW with idx=0 (no append); otherwise go to REQ.
  - i_start_round and i_clear are ignored whenever o_busy is high.
- REQ: drive o_gen_trigger=1 for exactly one cycle, load the timeout counter with 0, then go to WAIT_GEN.
- WAIT_GEN:
  - The counter increments each cycle.
  - If i_gen_ready is sampled high, capture i_gen_value and go to APPEND.
  - If the counter reaches GEN_TIMEOUT without ready, pulse o_error and return to IDLE with length unchanged.
  - i_gen_ready in any other state is ignored.
- APPEND: write the captured value to mem[length], length+=1, idx=0, go to SHOW.
- SHOW:
  - o_color=mem[idx] and o_led_valid=1 for exactly SHOW_CYCLES cycles, then go to GAP.
- GAP:
  - o_led_valid=0 for exactly GAP_CYCLES cycles.
  - Then, if idx==length-1, go to DONE; otherwise idx+=1 and go to SHOW.
- DONE: o_done=1 for one cycle, then IDLE.
- Latency: first o_led_valid cycle = 2 cycles (REQ, APPEND) + generator latency after the start cycle.
- Total playback duration = length × (SHOW_CYCLES + GAP_CYCLES) cycles.
- o_length is registered and updates the cycle after APPEND or clear.
- o_full is combinational from length.
- Width rules: idx and length are LEN_W bits. Length never exceeds MAX_LEN, and there is no wrap-around.

Test Plan:
1. Reset, then i_start_round with a generator model returning ready 2 cycles after trigger, value 2'b10 -> exactly one o_gen_trigger pulse; o_length=1. o_led_valid high 25 cycles with o_color=2, low 10 cycles, then o_done pulse; o_busy low afterwards.
2. Three rounds with values 1, 3, 0 -> third playback shows colours 1, 3, 0 in order over 105 cycles. i_rd_idx=0/1/2 reads 1/3/0; i_rd_idx=3 reads 0.
3. Generator never asserts ready -> o_error pulses 15 cycles after WAIT_GEN entry; o_length unchanged; state IDLE; no LED activity.
4. Fill to MAX_LEN=32, then i_start_round -> o_full=1, no o_gen_trigger, playback of 32 steps, o_done; o_length stays 32.
5. i_clear and i_start_round in the same idle cycle -> o_length=0 next cycle, no trigger. i_start_round during SHOW -> ignored, with no restart or extra trigger.
6. i_rst asserted mid-SHOW of round 2 -> next cycle o_led_valid=0, o_busy=0, o_length=0, no o_done pulse. i_enable dropped mid-GAP -> IDLE with o_length retained.

Source files
------------

// File: rtl/sequence_controller_if.sv
// Generator handshake bundle: enable and trigger towards the colour
// generator, ready strobe and 2-bit colour code back from it.
interface sequence_controller_if;
  logic       o_gen_enable;
  logic       o_gen_trigger;
  logic       i_gen_ready;
  logic [1:0] i_gen_value;

  // Controller side drives enable/trigger and consumes ready/value
  modport master (
    output o_gen_enable,
    output o_gen_trigger,
    input  i_gen_ready,
    input  i_gen_value
  );

  // Generator side answers a trigger with a ready strobe and a value
  modport slave (
    input  o_gen_enable,
    input  o_gen_trigger,
    output i_gen_ready,
    output i_gen_value
  );
endinterface

// File: rtl/sequence_controller.sv
// Simon game sequencer: on each round it fetches one colour from the
// generator, appends it to the stored sequence and replays the whole
// sequence as timed LED steps. A combinational read port exposes the
// stored sequence to the player-input checker.
module sequence_controller #(
  parameter  int MAX_LEN     = 32,
  parameter  int SHOW_CYCLES = 25,
  parameter  int GAP_CYCLES  = 10,
  parameter  int GEN_TIMEOUT = 15,
  localparam int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_start_round,
  input  logic                 i_clear,
  sequence_controller_if.master gen,
  output logic [1:0]           o_color,
  output logic                 o_led_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_full,
  output logic [LEN_W-1:0]     o_length,
  input  logic [LEN_W-1:0]     i_rd_idx,
  output logic [1:0]           o_rd_color
);

  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_GEN,
    APPEND,
    SHOW,
    GAP,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   length;
  logic [LEN_W-1:0]   idx;
  logic [1:0]         captured;
  logic               error_q;
  logic [1:0]         mem [MAX_LEN];

  logic               full;
  logic               last_step;
  logic               show_end;
  logic               gap_end;
  logic               gen_expired;

  // The shared counter times the generator wait and both LED phases
  assign full        = (length == LEN_W'(MAX_LEN));
  assign last_step   = (idx == length - LEN_W'(1));
  assign show_end    = (cnt == CNT_W'(SHOW_CYCLES - 1));
  assign gap_end     = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign gen_expired = (cnt == CNT_W'(GEN_TIMEOUT - 1));

  // State register; reset and a dropped enable both return to IDLE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start is only honoured from IDLE without a clear
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_start_round && !i_clear && i_enable) begin
          next_state = full ? SHOW : REQ;
        end
      end
      REQ:      next_state = WAIT_GEN;
      WAIT_GEN: begin
        if (gen.i_gen_ready) begin
          next_state = APPEND;
        end else if (gen_expired) begin
          next_state = IDLE;
        end
      end
      APPEND:   next_state = SHOW;
      SHOW:     if (show_end) next_state = GAP;
      GAP: begin
        if (gap_end) begin
          next_state = last_step ? DONE : SHOW;
        end
      end
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (!i_enable) begin
      next_state = IDLE;
    end
  end

  // Datapath: counter, step index, length, captured colour, error pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      idx      <= '0;
      length   <= '0;
      captured <= 2'b00;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (state == IDLE && i_clear) begin
        length <= '0;
      end
      if (i_enable) begin
        case (state)
          IDLE: begin
            cnt <= '0;
            idx <= '0;
          end
          REQ: cnt <= '0;
          WAIT_GEN: begin
            cnt <= cnt + CNT_W'(1);
            if (gen.i_gen_ready) begin
              captured <= gen.i_gen_value;
            end else if (gen_expired) begin
              error_q <= 1'b1;
            end
          end
          APPEND: begin
            length <= length + LEN_W'(1);
            idx    <= '0;
            cnt    <= '0;
          end
          SHOW: cnt <= show_end ? '0 : cnt + CNT_W'(1);
          GAP: begin
            if (gap_end) begin
              cnt <= '0;
              if (!last_step) begin
                idx <= idx + LEN_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  // Sequence memory has no reset; entries at or above length are never read
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_enable && state == APPEND) begin
      mem[length[ADDR_W-1:0]] <= captured;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    gen.o_gen_trigger = (state == REQ);
    o_led_valid       = (state == SHOW);
    o_busy            = (state != IDLE);
    o_done            = (state == DONE);
    o_color           = (state == SHOW) ? mem[idx[ADDR_W-1:0]] : 2'b00;
  end

  assign gen.o_gen_enable = i_enable;
  assign o_error          = error_q;
  assign o_full           = full;
  assign o_length         = length;
  assign o_rd_color       = (i_rd_idx < length) ? mem[i_rd_idx[ADDR_W-1:0]] : 2'b00;

endmodule
